// File: rtl/lcd_refresh_master.sv
// Wishbone master that runs the HD44780 init sequence and then mirrors a 2x16
// character shadow buffer onto the LCD, one command/data byte per transaction.
module lcd_refresh_master #(
    parameter logic [29:0] LCD_BASE      = 30'h0,
    parameter int unsigned POWERUP_DELAY = 750000,
    parameter int unsigned CMD_GAP       = 2000,
    parameter int unsigned CLEAR_DELAY   = 80000,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_char_we,
    input  logic [4:0]  i_char_addr,
    input  logic [7:0]  i_char_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_GAP
    } state_t;

    typedef enum logic {
        M_INIT,
        M_REFRESH
    } mode_t;

    logic [7:0]  shadow_q [32];

    state_t      state_q;
    mode_t       mode_q;
    logic [5:0]  step_q;
    logic [31:0] delay_q;
    logic [31:0] tmo_q;
    logic        dirty_q;

    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic        sel_q;
    logic [29:0] addr_q;
    logic [7:0]  byte_q;
    logic        init_done_q;
    logic        err_q;

    mode_t       issue_mode;
    logic [5:0]  issue_step;
    logic [5:0]  char_idx6;
    logic [7:0]  issue_byte;
    logic        issue_rs;
    logic        last_step;
    logic        got_ack;
    logic        abort;
    logic        start;
    logic [31:0] gap_len;

    always_ff @(posedge i_clk) begin
        if (i_char_we) begin
            shadow_q[i_char_addr] <= i_char_data;
        end
    end

    // Byte for the transaction about to be issued: the first step of a new
    // sequence, or the step after the one whose gap is expiring.
    always_comb begin
        issue_mode = (state_q == S_IDLE) ? M_REFRESH : mode_q;
        issue_step = (state_q == S_GAP) ? (step_q + 6'd1) : 6'd0;
        char_idx6  = (issue_step <= 6'd16) ? (issue_step - 6'd1) : (issue_step - 6'd2);
        issue_byte = 8'h00;
        issue_rs   = 1'b0;
        if (issue_mode == M_INIT) begin
            case (issue_step[1:0])
                2'd0:    issue_byte = 8'h38;
                2'd1:    issue_byte = 8'h0C;
                2'd2:    issue_byte = 8'h01;
                default: issue_byte = 8'h06;
            endcase
        end else if (issue_step == 6'd0) begin
            issue_byte = 8'h80;
        end else if (issue_step == 6'd17) begin
            issue_byte = 8'hC0;
        end else begin
            issue_byte = shadow_q[char_idx6[4:0]];
            issue_rs   = 1'b1;
        end
    end

    always_comb begin
        last_step = (mode_q == M_INIT) ? (step_q == 6'd3) : (step_q == 6'd33);
        gap_len   = (!addr_q[0] && byte_q == 8'h01) ? CLEAR_DELAY : CMD_GAP;
        got_ack   = ((state_q == S_BUS_REQ) && !i_wb_stall && i_wb_ack) ||
                    ((state_q == S_BUS_WAIT) && i_wb_ack);
        abort     = ((state_q == S_BUS_REQ) || (state_q == S_BUS_WAIT)) && !got_ack &&
                    (tmo_q == ACK_TIMEOUT - 32'd1);
        start     = ((state_q == S_PWRUP) && (delay_q == 32'd0)) ||
                    ((state_q == S_IDLE) && dirty_q) ||
                    ((state_q == S_GAP) && (delay_q == 32'd0) && !last_step);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_PWRUP;
            mode_q      <= M_INIT;
            step_q      <= 6'd0;
            delay_q     <= POWERUP_DELAY;
            tmo_q       <= 32'd0;
            dirty_q     <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 1'b0;
            addr_q      <= 30'd0;
            byte_q      <= 8'd0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_PWRUP: begin
                    if (delay_q != 32'd0) delay_q <= delay_q - 32'd1;
                end
                S_IDLE: begin
                    dirty_q <= 1'b0;
                end
                S_BUS_REQ: begin
                    tmo_q <= tmo_q + 32'd1;
                    if (!i_wb_stall) begin
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= 1'b0;
                        state_q <= S_BUS_WAIT;
                    end
                end
                S_BUS_WAIT: begin
                    tmo_q <= tmo_q + 32'd1;
                end
                S_GAP: begin
                    if (delay_q != 32'd0) begin
                        delay_q <= delay_q - 32'd1;
                    end else if (last_step) begin
                        state_q <= S_IDLE;
                        if (mode_q == M_INIT) init_done_q <= 1'b1;
                    end
                end
                default: state_q <= S_PWRUP;
            endcase

            if (got_ack) begin
                cyc_q   <= 1'b0;
                delay_q <= gap_len;
                state_q <= S_GAP;
            end

            // A hung slave abandons the whole sequence, not just the byte.
            if (abort) begin
                cyc_q <= 1'b0;
                stb_q <= 1'b0;
                we_q  <= 1'b0;
                sel_q <= 1'b0;
                err_q <= 1'b1;
                if (mode_q == M_INIT) begin
                    state_q <= S_PWRUP;
                    delay_q <= POWERUP_DELAY;
                end else begin
                    state_q <= S_IDLE;
                    dirty_q <= 1'b1;
                end
            end

            if (start) begin
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
                we_q    <= 1'b1;
                sel_q   <= 1'b1;
                addr_q  <= LCD_BASE | {29'd0, issue_rs};
                byte_q  <= issue_byte;
                mode_q  <= issue_mode;
                step_q  <= issue_step;
                tmo_q   <= 32'd0;
                state_q <= S_BUS_REQ;
            end

            // A write landing while IDLE clears dirty still forces another pass.
            if (i_char_we) dirty_q <= 1'b1;
        end
    end

    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = we_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = {24'h0, byte_q};
    assign o_wb_sel    = {3'b000, sel_q};
    assign o_init_done = init_done_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_err       = err_q;

endmodule

// File: tb/tb_lcd_refresh_master.sv
// Directed bench for lcd_refresh_master: a responsive slave on the main
// instance and a slave that never acks on a second, short-timeout instance.
module tb_lcd_refresh_master;

    localparam logic [29:0] BASE = 30'h100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        char_we;
    logic [4:0]  char_addr;
    logic [7:0]  char_data;
    logic        cyc, stb, we, init_done, busy, err;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        ack, stall;

    logic        t_cyc, t_stb, t_we, t_init_done, t_busy, t_err;
    logic [29:0] t_addr;
    logic [31:0] t_data;
    logic [3:0]  t_sel;
    logic        t_ack, t_stall;

    lcd_refresh_master #(
        .LCD_BASE(BASE), .POWERUP_DELAY(10), .CMD_GAP(3), .CLEAR_DELAY(20), .ACK_TIMEOUT(255)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_char_we(char_we), .i_char_addr(char_addr),
        .i_char_data(char_data), .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we),
        .o_wb_addr(addr), .o_wb_data(data), .o_wb_sel(sel), .i_wb_ack(ack),
        .i_wb_stall(stall), .o_init_done(init_done), .o_busy(busy), .o_err(err)
    );

    lcd_refresh_master #(
        .LCD_BASE(BASE), .POWERUP_DELAY(10), .CMD_GAP(3), .CLEAR_DELAY(20), .ACK_TIMEOUT(8)
    ) dut_to (
        .i_clk(clk), .i_reset(rst), .i_char_we(char_we), .i_char_addr(char_addr),
        .i_char_data(char_data), .o_wb_cyc(t_cyc), .o_wb_stb(t_stb), .o_wb_we(t_we),
        .o_wb_addr(t_addr), .o_wb_data(t_data), .o_wb_sel(t_sel), .i_wb_ack(t_ack),
        .i_wb_stall(t_stall), .o_init_done(t_init_done), .o_busy(t_busy), .o_err(t_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model [32];
    logic [7:0]  hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    logic [8:0]  acc_q [$];
    int          acc_stalls [$];
    int          gap_q [$];
    int          idone_low_q [$];
    int          hold_bad = 0;
    int          bus_bad = 0;
    logic        stall_en = 1'b0;

    int          to_hi_len = -1;
    int          to_low_len = -1;
    logic        to_err_early = 1'b0;
    logic        to_err_at_fall = 1'b0;
    logic        to_stb_at_fall = 1'b1;
    logic        to_we_at_fall = 1'b1;
    logic [3:0]  to_sel_at_fall = 4'hF;
    logic [7:0]  to_d1 = 8'h00;
    logic [7:0]  to_d2 = 8'h00;
    logic [29:0] to_a2 = 30'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_char(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        char_we = 1'b1; char_addr = a; char_data = d; model[a] = d;
        @(negedge clk);
        char_we = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag);
        int k = 0;
        while (acc_q.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic chk_refresh(input int b);
        for (int i = 0; i < 34; i++) begin
            logic [8:0] e;
            if (i == 0)       e = 9'h080;
            else if (i <= 16) e = {1'b1, model[i-1]};
            else if (i == 17) e = 9'h0C0;
            else              e = {1'b1, model[i-2]};
            chk($sformatf("refresh%0d_txn%0d", b, i), 32'(acc_q[b+i]), 32'(e));
        end
    endtask

    // Slave: stalls the first 5 cycles of a request when enabled, acks 2 cycles after accept.
    initial begin : slave
        int age, stbn;
        bit pend;
        logic [29:0] ha;
        logic [31:0] hd;
        age = 0; stbn = 0; pend = 0; ha = '0; hd = '0;
        ack = 1'b0; stall = 1'b0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            if (pend) begin
                age++;
                if (age == 2) begin ack = 1'b1; pend = 0; end
            end
            if (stb === 1'b1) begin
                stbn++;
                if (stbn == 1) begin ha = addr; hd = data; end
                else if (addr !== ha || data !== hd) hold_bad++;
                stall = stall_en && (stbn <= 5);
                if (!stall) begin
                    acc_q.push_back({addr[0], data[7:0]});
                    acc_stalls.push_back(stbn - 1);
                    if ((addr >> 1) !== (BASE >> 1) || we !== 1'b1 || sel !== 4'b0001 ||
                        (data >> 8) !== 32'd0) bus_bad++;
                    pend = 1; age = 0;
                end
            end else begin
                stbn = 0;
                stall = 1'b0;
            end
        end
    end

    initial begin : gap_mon
        int lo;
        bit hi_prev, id_prev;
        lo = 0; hi_prev = 0; id_prev = 0;
        forever begin
            @(negedge clk);
            if (cyc === 1'b1) begin
                if (!hi_prev) gap_q.push_back(lo);
                lo = 0; hi_prev = 1;
            end else begin
                lo++; hi_prev = 0;
            end
            if (init_done === 1'b1 && !id_prev) idone_low_q.push_back(lo);
            id_prev = (init_done === 1'b1);
        end
    end

    initial begin : to_mon
        int hi, lo, ph;
        hi = 0; lo = 0; ph = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                hi = 0; lo = 0;
            end else if (t_cyc === 1'b1) begin
                if (hi == 0 && ph == 0) to_d1 = t_data[7:0];
                if (hi == 0 && ph == 1) begin
                    to_low_len = lo; to_d2 = t_data[7:0]; to_a2 = t_addr; ph = 2;
                end
                if (ph == 0 && t_err === 1'b1) to_err_early = 1'b1;
                hi++; lo = 0;
            end else begin
                if (hi > 0 && ph == 0) begin
                    to_hi_len = hi; to_err_at_fall = t_err; to_stb_at_fall = t_stb;
                    to_we_at_fall = t_we; to_sel_at_fall = t_sel; ph = 1;
                end
                lo++; hi = 0;
            end
        end
    end

    initial begin : main
        int b, k;
        rst = 1'b1; char_we = 1'b0; char_addr = 5'd0; char_data = 8'd0;
        t_ack = 1'b0; t_stall = 1'b0;

        for (int i = 0; i < 32; i++) write_char(5'(i), (i < 5) ? hello[i] : 8'h20);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Init sequence
        wait_acc(4, 600, "init_wait");
        k = 0;
        while (init_done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("init_done_rise", 32'(init_done), 32'd1);
        chk("init_b0", 32'(acc_q[0]), 32'h038);
        chk("init_b1", 32'(acc_q[1]), 32'h00C);
        chk("init_b2", 32'(acc_q[2]), 32'h001);
        chk("init_b3", 32'(acc_q[3]), 32'h006);
        chk("gap_after_38", 32'(gap_q[1]), 32'd4);
        chk("gap_after_0C", 32'(gap_q[2]), 32'd4);
        chk("gap_after_01", 32'(gap_q[3]), 32'd21);
        chk("init_done_after_gap", 32'(idone_low_q[0]), 32'd5);

        // Timeout instance: cyc high 8 cycles, err set, restart from power-up delay
        chk("to_cyc_high_len", 32'(to_hi_len), 32'd8);
        chk("to_err_before", 32'(to_err_early), 32'd0);
        chk("to_err_at_drop", 32'(to_err_at_fall), 32'd1);
        chk("to_stb_at_drop", 32'(to_stb_at_fall), 32'd0);
        chk("to_we_at_drop", 32'(to_we_at_fall), 32'd0);
        chk("to_sel_at_drop", 32'(to_sel_at_fall), 32'd0);
        chk("to_first_byte", 32'(to_d1), 32'h38);
        chk("to_restart_gap", 32'(to_low_len), 32'd11);
        chk("to_restart_byte", 32'(to_d2), 32'h38);
        chk("to_restart_addr", 32'(to_a2), 32'(BASE));

        // First refresh: HELLO + spaces
        wait_acc(38, 1500, "refresh1_wait");
        wait_idle(200, "refresh1_idle");
        chk("r1_set_ddram_row0", 32'(acc_q[4]), 32'h080);
        chk("r1_char_H", 32'(acc_q[5]), 32'h148);
        chk("r1_char_O", 32'(acc_q[9]), 32'h14F);
        chk("r1_set_ddram_row1", 32'(acc_q[21]), 32'h0C0);
        chk("r1_last_space", 32'(acc_q[37]), 32'h120);
        chk_refresh(4);
        repeat (40) @(negedge clk);
        chk("r1_no_extra_txn", 32'(acc_q.size()), 32'd38);
        chk("r1_busy_low", 32'(busy), 32'd0);

        // Stalled refresh
        stall_en = 1'b1;
        write_char(5'd0, 8'h68);
        wait_acc(72, 3000, "stall_wait");
        wait_idle(300, "stall_idle");
        stall_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("stall_txn_count", 32'(acc_q.size()), 32'd72);
        chk("stall_char_h", 32'(acc_q[39]), 32'h168);
        chk_refresh(38);
        for (int i = 38; i < 72; i++) chk($sformatf("stall_cycles%0d", i), 32'(acc_stalls[i]), 32'd5);
        chk("stall_hold_stable", 32'(hold_bad), 32'd0);

        // Char write during the 10th refresh transaction forces a second refresh
        write_char(5'd0, 8'h48);
        b = acc_q.size();
        wait_acc(b + 10, 800, "mid_wait10");
        write_char(5'h10, 8'h41);
        wait_acc(b + 68, 3000, "mid_wait68");
        wait_idle(300, "mid_idle");
        repeat (60) @(negedge clk);
        chk("mid_txn_count", 32'(acc_q.size()), 32'(b + 68));
        chk("mid_first_row1_c0", 32'(acc_q[b+18]), 32'h141);
        chk("mid_second_row1_c0", 32'(acc_q[b+34+18]), 32'h141);
        chk_refresh(b);
        chk_refresh(b + 34);
        chk("to_err_sticky", 32'(t_err), 32'd1);
        chk("to_never_init_done", 32'(t_init_done), 32'd0);
        chk("to_busy", 32'(t_busy), 32'd1);
        chk("main_err_clear", 32'(err), 32'd0);

        // Reset while waiting for an ack
        write_char(5'd1, 8'h45);
        k = 0;
        while (!(cyc === 1'b1 && stb === 1'b0) && k < 200) begin @(negedge clk); k++; end
        chk("found_bus_wait", 32'(cyc === 1'b1 && stb === 1'b0), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstw_cyc", 32'(cyc), 32'd0);
        chk("rstw_stb", 32'(stb), 32'd0);
        chk("rstw_init_done", 32'(init_done), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd1);
        chk("rstw_to_err_cleared", 32'(t_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        b = acc_q.size();
        wait_acc(b + 4, 600, "replay_wait");
        k = 0;
        while (init_done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("replay_init_done", 32'(init_done), 32'd1);
        chk("replay_b0", 32'(acc_q[b]), 32'h038);
        chk("replay_b1", 32'(acc_q[b+1]), 32'h00C);
        chk("replay_b2", 32'(acc_q[b+2]), 32'h001);
        chk("replay_b3", 32'(acc_q[b+3]), 32'h006);
        chk("bus_fields", 32'(bus_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
